// File: rtl/sblk_inst_disp_pkg.sv
// Shared definitions for the superblock instruction dispatcher: FSM encoding,
// instruction field widths and the default row count.
package sblk_inst_disp_pkg;

  localparam int TN_W = 3;
  localparam int TM_W = 3;
  localparam int TP_W = 2;
  localparam int LN_W = 3;
  localparam int LP_W = 3;
  localparam int INST_W = TN_W + TM_W + TP_W + LN_W + LP_W;

  localparam int N_ROW_DEF = 3;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_SYNC  = 2'd2;

  typedef struct packed {
    logic [TN_W-1:0] tn;
    logic [TM_W-1:0] tm;
    logic [TP_W-1:0] tp;
    logic [LN_W-1:0] ln;
    logic [LP_W-1:0] lp;
  } inst_t;

endpackage

// File: rtl/sblk_inst_disp_ack_trk.sv
// Per-row pending tracker: holds a row busy from issue until the row reports
// busy, or until the acknowledge window expires.
module sblk_ack_trk #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk_l,
  input  logic rst_n,
  input  logic issue,
  input  logic strobe,
  input  logic busy,
  output logic pend,
  output logic timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          ack;

  // Busy seen during the strobe cycle itself predates the issue and is ignored.
  assign ack     = pend && busy && !strobe;
  assign timeout = pend && !ack && (cnt == LAST);

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (issue) begin
      pend <= 1'b1;
      cnt  <= '0;
    end else if (ack || timeout) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (pend) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sblk_inst_disp.sv
// Superblock instruction dispatcher: accepts masked instructions, strobes them
// to free rows one cycle later, and optionally barriers until all rows drain.
module sblk_inst_disp
  import sblk_inst_disp_pkg::*;
#(
  parameter int N_ROW       = N_ROW_DEF,
  parameter int WID_INST    = INST_W,
  parameter int ACK_TIMEOUT = 15,
  parameter int WID_CNT     = 16
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic [WID_INST-1:0]       in_inst,
  input  logic [N_ROW-1:0]          in_mask,
  input  logic                      in_sync,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic [WID_CNT-1:0]        issue_cnt,
  output logic                      err_timeout,
  output logic                      idle
);

  state_t             state;
  logic               sync_q;
  logic               accept;
  logic [N_ROW-1:0]   pend;
  logic [N_ROW-1:0]   tmo;
  logic [N_ROW-1:0]   free;
  logic [WID_CNT-1:0] mask_cnt;

  assign free   = ~status_sblk & ~pend;
  assign in_rdy = rst_n && (state == S_IDLE) && ((in_mask & ~free) == '0);
  assign accept = in_vld && in_rdy;
  assign idle   = (state == S_IDLE) && (&free);

  always_comb begin
    mask_cnt = '0;
    for (int r = 0; r < N_ROW; r++) begin
      mask_cnt = mask_cnt + WID_CNT'(in_mask[r]);
    end
  end

  for (genvar r = 0; r < N_ROW; r++) begin : g_trk
    sblk_ack_trk #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_trk (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .issue   (accept && in_mask[r]),
      .strobe  (inst_en[r]),
      .busy    (status_sblk[r]),
      .pend    (pend[r]),
      .timeout (tmo[r])
    );
  end

  // Accepts only happen in S_IDLE and are always followed by S_ISSUE, so a
  // row can never be strobed on two consecutive cycles.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sync_q  <= 1'b0;
      inst_en <= '0;
    end else begin
      inst_en <= '0;
      case (state)
        S_IDLE: if (accept) begin
          inst_en <= in_mask;
          sync_q  <= in_sync;
          state   <= S_ISSUE;
        end
        S_ISSUE: state <= sync_q ? S_SYNC : S_IDLE;
        S_SYNC:  if (&free) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      inst_data   <= '0;
      issue_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        issue_cnt <= issue_cnt + mask_cnt;
        for (int r = 0; r < N_ROW; r++) begin
          if (in_mask[r]) inst_data[r*WID_INST +: WID_INST] <= in_inst;
        end
      end
      if (|tmo) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sblk_inst_disp.sv
// Scoreboard bench for sblk_inst_disp: directed entries push expected strobes,
// a negedge monitor pops and compares them; timing checks run inline.
module tb_sblk_inst_disp;

  localparam int NR  = 3;
  localparam int WI  = 14;
  localparam int ATO = 15;
  localparam int WC  = 16;

  logic             clk_l = 1'b0;
  logic             rst_n;
  logic [WI-1:0]    in_inst;
  logic [NR-1:0]    in_mask;
  logic             in_sync;
  logic             in_vld;
  logic             in_rdy;
  logic [WI*NR-1:0] inst_data;
  logic [NR-1:0]    inst_en;
  logic [NR-1:0]    status_sblk;
  logic [WC-1:0]    issue_cnt;
  logic             err_timeout;
  logic             idle;

  typedef struct {
    int               cyc;
    logic [NR-1:0]    mask;
    logic [WI*NR-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [WI*NR-1:0] exp_data;
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;

  sblk_inst_disp #(
    .N_ROW(NR), .WID_INST(WI), .ACK_TIMEOUT(ATO), .WID_CNT(WC)
  ) dut (
    .clk_l       (clk_l),
    .rst_n       (rst_n),
    .in_inst     (in_inst),
    .in_mask     (in_mask),
    .in_sync     (in_sync),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .inst_data   (inst_data),
    .inst_en     (inst_en),
    .status_sblk (status_sblk),
    .issue_cnt   (issue_cnt),
    .err_timeout (err_timeout),
    .idle        (idle)
  );

  initial forever #5 clk_l = ~clk_l;

  always @(posedge clk_l) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every inst_en pulse must match the oldest queued entry.
  always @(negedge clk_l) begin
    if (inst_en !== '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", 64'(inst_en), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("strobe_cycle", 64'(cyc), 64'(e.cyc));
        checkOutput("inst_en", 64'(inst_en), 64'(e.mask));
        checkOutput("inst_data", 64'(inst_data), 64'(e.data));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic applyStimulus(input logic [NR-1:0] mask, input logic [WI-1:0] inst,
                               input logic sync);
    bit got;
    exp_t e;
    in_mask = mask; in_inst = inst; in_sync = sync; in_vld = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_l);
      if (in_rdy === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checkOutput("rdy_wait", 64'd0, 64'd1);
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (mask[r]) exp_data[r*WI +: WI] = inst;
      end
      if (mask != '0) begin
        e.cyc = cyc + 1; e.mask = mask; e.data = exp_data;
        sb.push_back(e);
      end
    end
    @(posedge clk_l); #1;
    in_vld = 1'b0; in_mask = '0; in_sync = 1'b0;
  endtask

  task automatic ackRows(input logic [NR-1:0] rows);
    @(posedge clk_l); #1 status_sblk = rows;
    @(posedge clk_l); #1 status_sblk = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_inst = '0; in_mask = '0; in_sync = 1'b0; in_vld = 1'b0;
    status_sblk = '0; exp_data = '0;
    repeat (3) @(posedge clk_l);
    @(negedge clk_l);
    checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("rst_inst_en", 64'(inst_en), 64'd0);
    checkOutput("rst_issue_cnt", 64'(issue_cnt), 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);
    checkOutput("rst_inst_data", 64'(inst_data), 64'd0);
    @(posedge clk_l); #1 rst_n = 1'b1;
    @(negedge clk_l);
    checkOutput("post_rst_idle", 64'(idle), 64'd1);
    checkOutput("post_rst_rdy", 64'(in_rdy), 64'd1);
    @(posedge clk_l); #1;

    // Single-row issue
    applyStimulus(3'b010, 14'h1234, 1'b0);
    ackRows(3'b010);
    @(negedge clk_l);
    checkOutput("cnt_single", 64'(issue_cnt), 64'd1);
    checkOutput("idle_single", 64'(idle), 64'd1);
    @(posedge clk_l); #1;

    // All rows while row 2 busy: must stall, then strobe together
    status_sblk = 3'b100;
    fork
      applyStimulus(3'b111, 14'h2aa5, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk_l);
          checkOutput("rdy_blocked", 64'(in_rdy), 64'd0);
        end
        @(posedge clk_l); #1 status_sblk = '0;
      end
    join
    ackRows(3'b111);
    @(negedge clk_l);
    checkOutput("cnt_all", 64'(issue_cnt), 64'd4);
    @(posedge clk_l); #1;

    // Sync entry: row 0 busy from strobe+4 to strobe+9
    applyStimulus(3'b001, 14'h0abc, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk_l); #1 status_sblk = (k >= 4 && k <= 9) ? 3'b001 : 3'b000;
      @(negedge clk_l);
      checkOutput($sformatf("sync_rdy_k%0d", k), 64'(in_rdy), (k <= 10) ? 64'd0 : 64'd1);
    end
    checkOutput("sync_idle", 64'(idle), 64'd1);
    checkOutput("cnt_sync", 64'(issue_cnt), 64'd5);
    @(posedge clk_l); #1;

    // Ack timeout on row 0
    applyStimulus(3'b001, 14'h0555, 1'b0);
    for (int k = 0; k <= ATO; k++) begin
      @(negedge clk_l);
      checkOutput($sformatf("err_k%0d", k), 64'(err_timeout), (k >= ATO) ? 64'd1 : 64'd0);
    end
    checkOutput("tmo_idle", 64'(idle), 64'd1);
    @(posedge clk_l); #1;
    applyStimulus(3'b001, 14'h0666, 1'b0);
    ackRows(3'b001);
    @(negedge clk_l);
    checkOutput("cnt_tmo", 64'(issue_cnt), 64'd7);
    checkOutput("err_sticky", 64'(err_timeout), 64'd1);
    @(posedge clk_l); #1;

    // Pure barrier
    applyStimulus(3'b000, 14'h3fff, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_l);
      checkOutput($sformatf("barrier_rdy_k%0d", k), 64'(in_rdy), (k < 2) ? 64'd0 : 64'd1);
    end
    @(posedge clk_l); #1;

    // Empty mask, no sync: discarded
    applyStimulus(3'b000, 14'h1111, 1'b0);
    @(negedge clk_l);
    checkOutput("discard_rdy0", 64'(in_rdy), 64'd0);
    @(negedge clk_l);
    checkOutput("discard_rdy1", 64'(in_rdy), 64'd1);
    checkOutput("cnt_discard", 64'(issue_cnt), 64'd7);
    @(posedge clk_l); #1;

    // Reset while in S_SYNC
    applyStimulus(3'b001, 14'h0f0f, 1'b1);
    @(posedge clk_l); #1;
    @(posedge clk_l); #1 rst_n = 1'b0;
    @(negedge clk_l);
    checkOutput("rst_sync_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk_l); #1;
    @(negedge clk_l);
    checkOutput("rst_sync_en", 64'(inst_en), 64'd0);
    checkOutput("rst_sync_cnt", 64'(issue_cnt), 64'd0);
    checkOutput("rst_sync_err", 64'(err_timeout), 64'd0);
    checkOutput("rst_sync_data", 64'(inst_data), 64'd0);
    checkOutput("rst_sync_rdy2", 64'(in_rdy), 64'd0);
    exp_data = '0;
    @(posedge clk_l); #1 rst_n = 1'b1;
    @(negedge clk_l);
    checkOutput("rst_sync_idle", 64'(idle), 64'd1);
    checkOutput("rst_sync_rdy3", 64'(in_rdy), 64'd1);
    repeat (2) @(negedge clk_l);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sblk_inst_disp.md
SBLK_INST_DISP -- requirements
Module: sblk_inst_disp

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_ROW, 3, number of superblock rows driven.
- WID_INST, 14, instruction width (TN 3 + TM 3 + TP 2 + LN 3 + LP 3).
- ACK_TIMEOUT, 15, max cycles from issue to observed busy.
- WID_CNT, 16, issue counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_l, in, 1, sole clock.
- rst_n, in, 1, synchronous active-low reset.
- in_inst, in, WID_INST, instruction payload.
- in_mask, in, N_ROW, target row mask.
- in_sync, in, 1, barrier after this entry.
- in_vld, in, 1, entry valid.
- in_rdy, out, 1, entry accepted when in_vld&&in_rdy.
- inst_data, out, WID_INST*N_ROW, row r slice [r*WID_INST +: WID_INST].
- inst_en, out, N_ROW, one-cycle issue strobe per row.
- status_sblk, in, N_ROW, 1 = row busy.
- issue_cnt, out, WID_CNT, total row-issues since reset.
- err_timeout, out, 1, sticky ack-timeout flag.
- idle, out, 1, FSM in S_IDLE and all rows free.

Function
REQ-003 Row r SHALL be free when status_sblk[r]==0 and pend[r]==0.
REQ-004 In S_IDLE, in_rdy SHALL equal (in_mask & ~free)==0; otherwise in_rdy SHALL be 0.
REQ-005 On accept, for each r with in_mask[r]: inst_data slice r SHALL load in_inst and inst_en[r] SHALL pulse high on the next cycle (latency 1).
REQ-006 inst_data slices SHALL hold their value until the next issue to that row.
REQ-007 inst_en SHALL never be high on a row for two consecutive cycles.
REQ-008 pend[r] SHALL set in the cycle inst_en[r] is high and clear on the first subsequent cycle with status_sblk[r]==1.
REQ-009 Per-row ack counter SHALL count cycles while pend[r]; on reaching ACK_TIMEOUT it SHALL clear pend[r] and set err_timeout.
REQ-010 err_timeout SHALL remain set until reset.
REQ-011 FSM states SHALL be S_IDLE, S_ISSUE, S_SYNC.
REQ-012 Transitions: S_IDLE->S_ISSUE on accept; S_ISSUE->S_SYNC if accepted in_sync, else S_IDLE; S_SYNC->S_IDLE when all rows free.
REQ-013 in_mask==0 with in_sync=1 SHALL be a pure barrier: no strobe, S_ISSUE then S_SYNC.
REQ-014 in_mask==0 with in_sync=0 SHALL be accepted and discarded.
REQ-015 issue_cnt SHALL add popcount(in_mask) per accept, wrapping modulo 2^WID_CNT.
REQ-016 status_sblk rising on a row without pend SHALL be ignored apart from its effect on free.
REQ-017 idle SHALL be combinational from state and free vector.

Reset
REQ-018 With rst_n==0 at a clk_l edge: state=S_IDLE, pend=0, ack counters=0, inst_data=0, inst_en=0, issue_cnt=0, err_timeout=0.
REQ-019 Reset mid-issue or mid-sync SHALL drop the in-flight entry with no strobe in the following cycle.
REQ-020 in_rdy SHALL be 0 during reset.

Structure
REQ-021 Shared package SHALL hold the FSM state enum, instruction field widths (TN/TM/TP/LN/LP) and default N_ROW.
REQ-022 Pend/ack-counter logic SHALL be one sub-module, sblk_ack_trk, instantiated N_ROW times.

Verification
REQ-023 Mask 3'b010, inst 14'h1234, status 0 -> inst_en=3'b010 one cycle after accept, slice1=14'h1234, issue_cnt=1.
REQ-024 Mask 3'b111 while status_sblk[2]=1 -> in_rdy=0 until status_sblk[2] falls, then all three strobe together, issue_cnt=3.
REQ-025 Mask 3'b001 with sync=1, status[0] high 4 cycles after strobe then low at cycle 10 -> in_rdy=0 through cycle 10, idle=1 after.
REQ-026 Issue to row 0, status held 0 -> err_timeout=1 exactly ACK_TIMEOUT cycles after strobe, pend cleared, next entry accepted.
REQ-027 Barrier (mask 0, sync 1) with rows idle -> no inst_en, in_rdy low 2 cycles, then high.
REQ-028 Reset asserted in S_SYNC -> next cycle state S_IDLE, all outputs zero, in_rdy=0 while rst_n=0.
